// File: rtl/parameterized_piso.sv
// Parallel-in/serial-out unloader: accepts a W-bit word through a ready/load
// handshake and streams it out one bit per clock with valid and last-bit flags.
module parameterized_piso #(
    parameter int W         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sclr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic         ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         done
);

    localparam int            CW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state, state_nx;
    logic [W-1:0]  shreg, shreg_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          sout_nx, valid_nx;
    logic          accept;

    // The register always holds the bits still to be sent, so the next bit is at the head.
    function automatic logic head(input logic [W-1:0] v);
        return MSB_FIRST ? v[W-1] : v[0];
    endfunction

    function automatic logic [W-1:0] advance(input logic [W-1:0] v);
        return MSB_FIRST ? {v[W-2:0], 1'b0} : {1'b0, v[W-1:1]};
    endfunction

    assign done   = sout_valid & (cnt == LAST);
    assign ready  = (state == IDLE) | done;
    assign accept = load & ready & ~sclr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            shreg      <= shreg_nx;
            cnt        <= cnt_nx;
            sout       <= sout_nx;
            sout_valid <= valid_nx;
        end
    end

    // Accept on the last bit reloads directly, giving a gapless back-to-back stream.
    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        cnt_nx   = cnt;
        sout_nx  = sout;
        valid_nx = sout_valid;
        if (sclr) begin
            state_nx = IDLE;
            shreg_nx = '0;
            cnt_nx   = '0;
            sout_nx  = 1'b0;
            valid_nx = 1'b0;
        end else if (accept) begin
            state_nx = SHIFT;
            shreg_nx = advance(d);
            cnt_nx   = '0;
            sout_nx  = head(d);
            valid_nx = 1'b1;
        end else if (state == SHIFT) begin
            if (done) begin
                state_nx = IDLE;
                shreg_nx = '0;
                cnt_nx   = '0;
                sout_nx  = 1'b0;
                valid_nx = 1'b0;
            end else begin
                state_nx = SHIFT;
                shreg_nx = advance(shreg);
                cnt_nx   = cnt + CW'(1);
                sout_nx  = head(shreg);
                valid_nx = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_parameterized_piso.sv
// Bench for parameterized_piso: three instances (W=4 MSB-first, W=4 LSB-first,
// W=8 MSB-first) share stimulus and are compared each cycle with a bit-queue model.
module tb_parameterized_piso;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclr;
    logic       load;
    logic [7:0] d_in;
    logic [2:0] ready_o, sout_o, valid_o, done_o;

    int test_count = 0;
    int fail_count = 0;

    int width_of[3] = '{4, 4, 8};
    bit msb_of[3]   = '{1'b1, 1'b0, 1'b1};
    bit mbits[3][8];
    int mlen[3];

    always #5 clk = ~clk;

    parameterized_piso #(.W(4), .MSB_FIRST(1'b1)) u_msb4 (
        .clk(clk), .rst_n(rst_n), .sclr(sclr), .load(load), .d(d_in[3:0]),
        .ready(ready_o[0]), .sout(sout_o[0]), .sout_valid(valid_o[0]), .done(done_o[0])
    );

    parameterized_piso #(.W(4), .MSB_FIRST(1'b0)) u_lsb4 (
        .clk(clk), .rst_n(rst_n), .sclr(sclr), .load(load), .d(d_in[3:0]),
        .ready(ready_o[1]), .sout(sout_o[1]), .sout_valid(valid_o[1]), .done(done_o[1])
    );

    parameterized_piso #(.W(8), .MSB_FIRST(1'b1)) u_msb8 (
        .clk(clk), .rst_n(rst_n), .sclr(sclr), .load(load), .d(d_in),
        .ready(ready_o[2]), .sout(sout_o[2]), .sout_valid(valid_o[2]), .done(done_o[2])
    );

    // Model: each instance holds the list of bits still to appear; element 0 is on sout now.
    function automatic void modelReset();
        for (int i = 0; i < 3; i++) mlen[i] = 0;
    endfunction

    function automatic void modelStep(input bit ld, input logic [7:0] dv, input bit sc, input bit rn);
        for (int i = 0; i < 3; i++) begin
            bit rdy;
            rdy = (mlen[i] <= 1);
            if (!rn || sc) begin
                mlen[i] = 0;
            end else if (ld && rdy) begin
                mlen[i] = width_of[i];
                for (int k = 0; k < width_of[i]; k++)
                    mbits[i][k] = msb_of[i] ? dv[width_of[i]-1-k] : dv[k];
            end else if (mlen[i] > 0) begin
                for (int k = 0; k < 7; k++) mbits[i][k] = mbits[i][k+1];
                mlen[i] = mlen[i] - 1;
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        test_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic checkModel();
        for (int i = 0; i < 3; i++) begin
            logic es;
            es = (mlen[i] > 0) ? mbits[i][0] : 1'b0;
            checkOutput($sformatf("dut%0d_sout", i), sout_o[i], es);
            checkOutput($sformatf("dut%0d_valid", i), valid_o[i], mlen[i] > 0);
            checkOutput($sformatf("dut%0d_done", i), done_o[i], mlen[i] == 1);
            checkOutput($sformatf("dut%0d_ready", i), ready_o[i], mlen[i] <= 1);
        end
    endtask

    task automatic applyStimulus(input bit ld, input logic [7:0] dv, input bit sc);
        @(negedge clk);
        load = ld;
        d_in = dv;
        sclr = sc;
        @(posedge clk);
        modelStep(ld, dv, sc, rst_n);
        #1;
        checkModel();
    endtask

    task automatic expectBit(input int idx, input string tag, input logic s, input logic dn);
        checkOutput({tag, "_sout"}, sout_o[idx], s);
        checkOutput({tag, "_valid"}, valid_o[idx], 1'b1);
        checkOutput({tag, "_done"}, done_o[idx], dn);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        bit         rl, rs;
        logic [7:0] rd;
        logic [7:0] pat;

        load = 1'b0;
        sclr = 1'b0;
        d_in = 8'h00;
        rst_n = 1'b1;
        modelReset();
        #1 rst_n = 1'b0;
        #1 checkModel();
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        idleCycles(3);

        // MSB-first 1011
        applyStimulus(1'b1, 8'h0B, 1'b0); expectBit(0, "msb_b0", 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0); expectBit(0, "msb_b1", 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0); expectBit(0, "msb_b2", 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0); expectBit(0, "msb_b3", 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("msb_end_valid", valid_o[0], 1'b0);
        checkOutput("msb_end_ready", ready_o[0], 1'b1);
        idleCycles(8);

        // LSB-first 1011 with an ignored mid-word load of 0000
        applyStimulus(1'b1, 8'h0B, 1'b0); expectBit(1, "lsb_b0", 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0); expectBit(1, "lsb_b1", 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h00, 1'b0); expectBit(1, "lsb_b2", 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0); expectBit(1, "lsb_b3", 1'b1, 1'b1);
        idleCycles(9);

        // Back-to-back 1100 then 0011 loaded on the done cycle
        pat = 8'b1100_0011;
        applyStimulus(1'b1, 8'h0C, 1'b0); expectBit(0, "b2b_b0", pat[7], 1'b0);
        for (int k = 1; k < 8; k++) begin
            applyStimulus(k == 4, 8'h03, 1'b0);
            expectBit(0, $sformatf("b2b_b%0d", k), pat[7-k], (k == 3) || (k == 7));
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("b2b_end_valid", valid_o[0], 1'b0);
        idleCycles(9);

        // Synchronous clear mid-word, then a clean 1010
        applyStimulus(1'b1, 8'h0F, 1'b0); expectBit(0, "clr_b0", 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h0F, 1'b1);
        checkOutput("clr_sout", sout_o[0], 1'b0);
        checkOutput("clr_valid", valid_o[0], 1'b0);
        checkOutput("clr_done", done_o[0], 1'b0);
        checkOutput("clr_ready", ready_o[0], 1'b1);
        idleCycles(1);
        applyStimulus(1'b1, 8'h0A, 1'b0); expectBit(0, "aft_b0", 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0); expectBit(0, "aft_b1", 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0); expectBit(0, "aft_b2", 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0); expectBit(0, "aft_b3", 1'b0, 1'b1);
        idleCycles(9);

        // Asynchronous reset between edges during bit 3 of A5 on the 8-bit instance
        applyStimulus(1'b1, 8'hA5, 1'b0); expectBit(2, "ar_b0", 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0); expectBit(2, "ar_b1", 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0); expectBit(2, "ar_b2", 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("arst_sout", sout_o[2], 1'b0);
        checkOutput("arst_valid", valid_o[2], 1'b0);
        checkOutput("arst_ready", ready_o[2], 1'b1);
        checkModel();
        idleCycles(2);
        @(negedge clk) rst_n = 1'b1;
        pat = 8'h3C;
        applyStimulus(1'b1, 8'h3C, 1'b0); expectBit(2, "rel_b0", pat[7], 1'b0);
        for (int k = 1; k < 8; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            expectBit(2, $sformatf("rel_b%0d", k), pat[7-k], k == 7);
        end
        idleCycles(2);

        // Randomized traffic against the model
        repeat (400) begin
            rl = 1'($urandom_range(0, 1));
            rd = 8'($urandom);
            rs = ($urandom_range(0, 15) == 0);
            applyStimulus(rl, rd, rs);
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/parameterized_piso.md
# parameterized_piso

Parameterized parallel-in/serial-out unloader that takes a W-bit word (the same kind of word our parameterized latches hold) and shifts it out one bit per clock with a valid strobe. It is the read-out end of the latch datapath. It accepts a word through a ready/load handshake, streams it MSB- or LSB-first, and flags the last bit. A synchronous clear aborts a transfer in progress.

## Interface
- W, default 4: word width in bits; legal range W >= 2.
- MSB_FIRST, default 1: 1 = bit W-1 leaves first; 0 = bit 0 leaves first.

- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sclr  input  1  synchronous clear; aborts the transfer and returns the block to idle.
- load  input  1  request to capture d; accepted only when ready=1.
- d  input  W  parallel word to serialize.
- ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a valid bit.
- done  output  1  high on the cycle sout carries the last bit of a word.

## Operation
- Reset (rst_n=0, asynchronous): state=IDLE, shift register=0, bit counter=0, sout=0, sout_valid=0, done=0. ready=1 while rst_n=0.
- The FSM has two states: IDLE and SHIFT.
- ready is combinational: ready = (state==IDLE) | done.
- Accept is defined as load & ready & ~sclr, sampled at a rising edge.
  - On accept, d is captured into the shift register.
  - The counter is set to 0 and state becomes SHIFT.
  - The first bit appears on sout after that same edge.
- In SHIFT, each edge does the following:
  - presents the next bit (MSB_FIRST=1: d[W-1], d[W-2], …, d[0]; MSB_FIRST=0: d[0], …, d[W-1]);
  - increments the counter.
- The counter width is $clog2(W). The counter runs 0..W-1 and never wraps past W-1.
- done = sout_valid & (counter==W-1).
- On the edge after the done cycle:
  - if an accept occurred, the new word starts immediately and its first bit appears with no gap;
  - otherwise state=IDLE, sout=0, sout_valid=0.
- load while ready=0 (mid-word, not last bit) is ignored. d is not sampled and the current word is not disturbed.
- sclr=1 at an edge forces IDLE with sout=0, sout_valid=0, done=0, counter=0, shift register=0.
  - sclr has priority over load; a simultaneous load is dropped.
- Priority order: rst_n > sclr > accept > shift.
- d changes after the accept edge have no effect on the word in flight.

## Timing
- Latency: accept edge E0. Bit k (k=0..W-1) is valid on sout between edges E0+k and E0+k+1.
- sout_valid is high for exactly W consecutive cycles per word.
- done is high for exactly 1 cycle, coincident with bit W-1.
- Throughput: one word per W cycles when back-to-back loads are issued on done cycles.
  - With no load on a done cycle, one idle cycle minimum between words.
- All outputs are registered except ready (combinational from state/done). There is no combinational path from load or d to any output.
- Asynchronous reset asserted mid-word clears all outputs immediately, without waiting for a clock edge.
- After rst_n deasserts, the first accept may occur at the first rising edge.

## Test plan
- Reset values: hold rst_n=0 for 3 cycles, then release. Required: sout=0, sout_valid=0, done=0, ready=1, and they stay so with load=0.
- MSB-first word: W=4, MSB_FIRST=1, load d=4'b1011 for one cycle. Required:
  - sout = 1,0,1,1 on the next 4 cycles with sout_valid=1;
  - done high only on the 4th;
  - then sout_valid=0 and ready=1.
- LSB-first word, and load ignored while busy: W=4, MSB_FIRST=0, load d=4'b1011. Required: sout = 1,1,0,1. A load of d=4'b0000 on bit cycle 2 is ignored, and the stream is unchanged.
- Back-to-back: W=4, MSB_FIRST=1, load 4'b1100, then load 4'b0011 on the done cycle. Required:
  - continuous 8-bit stream 1,1,0,0,0,0,1,1 with sout_valid high for 8 cycles;
  - done pulses on cycles 4 and 8.
- Clear mid-word: load 4'b1111 and assert sclr together with load on bit cycle 2. Required:
  - next cycle sout=0, sout_valid=0, done=0, ready=1;
  - a subsequent load of 4'b1010 streams 1,0,1,0 correctly.
- Async reset mid-word: W=8, load 8'hA5 and pull rst_n low between clock edges during bit cycle 3. Required: sout_valid and sout drop to 0 immediately. After release, a load of 8'h3C streams 0,0,1,1,1,1,0,0.
